// File: rtl/serv_bufreg_seq.sv
// Sequencer for the nibble-serial buffer register.
// It takes one operation per start pulse and steps through INIT, SHIFT, MEM
// and RUN. It drives the buffer register strobes, the low bits of the shift
// counter and the dbus cycle request.
module serv_bufreg_seq #(
    parameter int BITS_PER_CYCLE = 4,
    parameter int LB             = $clog2(BITS_PER_CYCLE),
    parameter int CW             = $clog2(32 / BITS_PER_CYCLE)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_mem_op,
    input  logic          i_shift_op,
    input  logic [4:0]    i_shamt,
    input  logic          i_dbus_ack,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_en,
    output logic          o_init,
    output logic          o_cnt0,
    output logic          o_cnt1,
    output logic [LB-1:0] o_shift_counter_lsb,
    output logic          o_dbus_cyc
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        SHIFT = 3'd2,
        MEM   = 3'd3,
        RUN   = 3'd4
    } state_t;

    // Last count of an 8-cycle word phase (at the default width)
    localparam logic [CW-1:0] LAST = CW'(32 / BITS_PER_CYCLE - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_q, mem_d;
    logic          shift_q, shift_d;
    // The bulk shift count is the number of whole BITS_PER_CYCLE steps. It
    // is always below 32/BITS_PER_CYCLE, so it fits in the phase counter width.
    logic [CW-1:0] bulk_q, bulk_d;
    logic [LB-1:0] lsb_q, lsb_d;

    logic          last_phase;
    assign last_phase = (cnt_q == LAST);

    // Next-state, phase counter and operation latch logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        mem_d   = mem_q;
        shift_d = shift_q;
        bulk_d  = bulk_q;
        lsb_d   = lsb_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_start) begin
                    // If both op flags are set, a memory op takes priority over a shift op
                    mem_d   = i_mem_op;
                    shift_d = i_shift_op & ~i_mem_op;
                    bulk_d  = CW'(i_shamt >> LB);
                    lsb_d   = (i_shift_op & ~i_mem_op) ? i_shamt[LB-1:0] : '0;
                    state_d = INIT;
                end
            end
            INIT: begin
                if (last_phase) begin
                    cnt_d = '0;
                    if (mem_q)
                        state_d = MEM;
                    else if (shift_q && (bulk_q != '0))
                        state_d = SHIFT;
                    else if (shift_q)
                        state_d = RUN;
                    else
                        state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_q == bulk_q - CW'(1)) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            MEM: begin
                cnt_d = '0;
                if (i_dbus_ack)
                    state_d = IDLE;
            end
            RUN: begin
                if (last_phase) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // The latched shift amount reads zero whenever the sequencer is idle
        if (state_d == IDLE) begin
            lsb_d   = '0;
            mem_d   = 1'b0;
            shift_d = 1'b0;
        end
    end

    // State and operation registers with asynchronous reset to IDLE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mem_q   <= 1'b0;
            shift_q <= 1'b0;
            bulk_q  <= '0;
            lsb_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
            shift_q <= shift_d;
            bulk_q  <= bulk_d;
            lsb_q   <= lsb_d;
        end
    end

    // Output decode from the registered state. Only o_done in MEM follows
    // the ack input, so the done pulse lands on the ack cycle itself.
    always_comb begin
        o_busy              = (state_q != IDLE);
        o_en                = (state_q == INIT) || (state_q == SHIFT) || (state_q == RUN);
        o_init              = (state_q == INIT);
        o_cnt0              = ((state_q == INIT) || (state_q == RUN)) && (cnt_q == CW'(0));
        o_cnt1              = ((state_q == INIT) || (state_q == RUN)) && (cnt_q == CW'(1));
        o_dbus_cyc          = (state_q == MEM);
        o_shift_counter_lsb = lsb_q;
        o_done              = ((state_q == INIT) && last_phase && !mem_q && !shift_q) ||
                              ((state_q == RUN) && last_phase) ||
                              ((state_q == MEM) && i_dbus_ack);
    end

endmodule

// File: tb/tb_serv_bufreg_seq.sv
// Directed bench for serv_bufreg_seq. The expected outputs are listed cycle
// by cycle from the operation timings.
module tb_serv_bufreg_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic       mem_op;
    logic       shift_op;
    logic [4:0] shamt;
    logic       ack;
    logic       busy, done, en, init, cnt0, cnt1, dbus_cyc;
    logic [1:0] lsb;

    int pass_cnt  = 0;
    int total_cnt = 0;

    serv_bufreg_seq dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_start             (start),
        .i_mem_op            (mem_op),
        .i_shift_op          (shift_op),
        .i_shamt             (shamt),
        .i_dbus_ack          (ack),
        .o_busy              (busy),
        .o_done              (done),
        .o_en                (en),
        .o_init              (init),
        .o_cnt0              (cnt0),
        .o_cnt1              (cnt1),
        .o_shift_counter_lsb (lsb),
        .o_dbus_cyc          (dbus_cyc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view of the outputs: busy done en init cnt0 cnt1 cyc lsb[1:0]
    logic [8:0] o_vec;
    assign o_vec = {busy, done, en, init, cnt0, cnt1, dbus_cyc, lsb};

    function automatic logic [8:0] ev(input bit b, input bit d, input bit e, input bit i,
                                      input bit c0, input bit c1, input bit cy,
                                      input logic [1:0] l);
        return {b, d, e, i, c0, c1, cy, l};
    endfunction

    // Advance to the next cycle. Inputs are changed after this returns.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let the inputs settle, then compare the outputs of the current cycle
    task automatic chk(input string tag, input logic [8:0] exp);
        #1;
        total_cnt++;
        assert (o_vec === exp) pass_cnt++;
        else $error("FAIL %s obs=%b exp=%b (busy done en init c0 c1 cyc lsb)", tag, o_vec, exp);
    endtask

    // Eight INIT cycles, with done on the last cycle only for an address-only op
    task automatic init_phase(input string tag, input logic [1:0] l, input bit last_done);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s_init%0d", tag, k), ev(1, last_done && k == 7, 1, 1, k == 0, k == 1, 0, l));
            step();
            start = 1'b0;
        end
    endtask

    // Eight RUN cycles, with done on count 7
    task automatic run_phase(input string tag, input logic [1:0] l);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s_run%0d", tag, k), ev(1, k == 7, 1, 0, k == 0, k == 1, 0, l));
            step();
        end
    endtask

    // Full shift op. The bulk count and low bits are written out for each case.
    task automatic shift_op_run(input string tag, input logic [4:0] sh,
                                input int bulk, input logic [1:0] l);
        shift_op = 1'b1;
        shamt    = sh;
        start    = 1'b1;
        chk({tag, "_idle"}, 9'd0);
        step();
        start    = 1'b0;
        shift_op = 1'b0;
        shamt    = 5'd0;
        init_phase(tag, l, 1'b0);
        for (int k = 0; k < bulk; k++) begin
            chk($sformatf("%s_shift%0d", tag, k), ev(1, 0, 1, 0, 0, 0, 0, l));
            step();
        end
        run_phase(tag, l);
        chk({tag, "_after"}, 9'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        mem_op   = 1'b0;
        shift_op = 1'b0;
        shamt    = 5'd0;
        ack      = 1'b0;
        step();
        chk("reset_state", 9'd0);
        step();
        rst = 1'b0;
        $display("reset released");

        // Address-only op: 8 INIT cycles, done on cycle 8, idle on cycle 9
        start = 1'b1;
        chk("addr_idle", 9'd0);
        step();
        init_phase("addr", 2'd0, 1'b1);
        chk("addr_after", 9'd0);
        $display("address-only op: 8 cycles");

        // Shift ops: shamt 13 -> bulk 3, lsb 1; 2 -> no SHIFT, lsb 2; boundaries 31 and 4
        shift_op_run("sh13", 5'd13, 3, 2'd1);
        $display("shift op shamt=13");
        shift_op_run("sh2", 5'd2, 0, 2'd2);
        $display("shift op shamt=2");
        shift_op_run("sh31", 5'd31, 7, 2'd3);
        $display("shift op shamt=31");
        shift_op_run("sh4", 5'd4, 1, 2'd0);
        $display("shift op shamt=4");

        // Mem op, with the shift flag also set (mem wins, so lsb reads 0).
        // Acks in IDLE and INIT are ignored.
        mem_op   = 1'b1;
        shift_op = 1'b1;
        shamt    = 5'd13;
        ack      = 1'b1;
        start    = 1'b1;
        chk("mem_idle_ack", 9'd0);
        step();
        mem_op   = 1'b0;
        shift_op = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ack = (k % 2 == 0);
            chk($sformatf("mem_init%0d", k), ev(1, 0, 1, 1, k == 0, k == 1, 0, 2'd0));
            step();
            start = 1'b0;
        end
        for (int j = 0; j < 6; j++) begin
            ack = (j == 5);
            chk($sformatf("mem_wait%0d", j), ev(1, j == 5, 0, 0, 0, 0, 1, 2'd0));
            step();
        end
        ack = 1'b0;
        chk("mem_after", 9'd0);
        $display("mem op: dbus_cyc held 6 cycles");

        // Mem op with ack in the first MEM cycle gives a single MEM cycle
        mem_op = 1'b1;
        start  = 1'b1;
        chk("mem1_idle", 9'd0);
        step();
        mem_op = 1'b0;
        init_phase("mem1", 2'd0, 1'b0);
        ack = 1'b1;
        chk("mem1_ack", ev(1, 1, 0, 0, 0, 0, 1, 2'd0));
        step();
        ack = 1'b0;
        chk("mem1_after", 9'd0);
        $display("mem op: immediate ack");

        // Reset at RUN count 3 clears every output at once, then a new op runs normally
        shift_op = 1'b1;
        shamt    = 5'd2;
        start    = 1'b1;
        chk("rst_idle", 9'd0);
        step();
        shift_op = 1'b0;
        init_phase("rst", 2'd2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_run%0d", k), ev(1, 0, 1, 0, k == 0, k == 1, 0, 2'd2));
            step();
        end
        chk("rst_run3_pre", ev(1, 0, 1, 0, 0, 0, 0, 2'd2));
        rst = 1'b1;
        chk("rst_async", 9'd0);
        step();
        rst = 1'b0;
        chk("rst_post", 9'd0);
        start = 1'b1;
        chk("rst_restart_idle", 9'd0);
        step();
        init_phase("rst_restart", 2'd0, 1'b1);
        chk("rst_restart_after", 9'd0);
        $display("reset mid-RUN");

        // Start held high: one op runs, then a second op starts right after done
        start = 1'b1;
        chk("hold_idle", 9'd0);
        step();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("hold_init%0d", k), ev(1, k == 7, 1, 1, k == 0, k == 1, 0, 2'd0));
            step();
        end
        chk("hold_gap", 9'd0);
        step();
        init_phase("hold2", 2'd0, 1'b1);
        chk("hold2_after", 9'd0);
        $display("start held high");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
